// File: rtl/inst_rom_loader.sv
// inst_rom_loader: byte-stream program loader in front of a CPU instruction ROM.
// After reset the block sits in LOAD, holding the CPU and packing incoming
// little-endian bytes into 32-bit words. The byte flagged ld_last switches it
// to RUN, which releases the CPU and serves zero-latency fetches.
// Optional feature: define INST_ROM_ADDR_CHECK_EN to return NOP_WORD for
// fetches beyond the loaded image and to raise the sticky addr_err_o flag.
module inst_rom_loader #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  cpu_hold_o,
  output logic [DEPTH_LOG2:0]   ld_words_o,
  output logic                  ld_ovf_o
`ifdef INST_ROM_ADDR_CHECK_EN
  ,
  output logic                  addr_err_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_byte_cnt;
  logic [DEPTH_LOG2:0]   r_waddr;
  logic                  r_ovf;
  logic [31:0]           r_asm;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_full;
  logic                  w_store;
  logic [31:0]           w_word;
  logic                  w_fetch;
  logic [DEPTH_LOG2-1:0] w_ridx;
  logic [31:0]           w_raw;
  logic [31:0]           w_rdata;
  logic                  w_unused_addr;

  // Bytes are only taken while loading; ld_ready is high in LOAD so valid alone qualifies.
  assign w_accept = ld_valid && (r_state == ST_LOAD);
  // waddr reaches exactly 2^DEPTH_LOG2 once every word has been written.
  assign w_full   = r_waddr[DEPTH_LOG2];
  // A word is committed on lane 3 or on the final byte (partial word).
  assign w_store  = w_accept && !w_full && (ld_last || (r_byte_cnt == 2'd3));

  // Handshake/hold are forced high while reset is held so the CPU never runs early.
  assign ld_ready   = !rst || (r_state == ST_LOAD);
  assign cpu_hold_o = !rst || (r_state == ST_LOAD);
  assign ld_words_o = r_waddr;
  assign ld_ovf_o   = r_ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: the accepted last byte ends loading, even when memory is full.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_accept && ld_last) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Merge the incoming byte into its lane; lanes above it are still zero in r_asm.
  always_comb begin
    w_word = r_asm;
    case (r_byte_cnt)
      2'd0:    w_word[7:0]   = ld_data;
      2'd1:    w_word[15:8]  = ld_data;
      2'd2:    w_word[23:16] = ld_data;
      2'd3:    w_word[31:24] = ld_data;
      default: w_word        = r_asm;
    endcase
  end

  // Loader datapath: lane counter, write address/word count, overflow flag, assembly word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_byte_cnt <= 2'd0;
      r_waddr    <= '0;
      r_ovf      <= 1'b0;
      r_asm      <= 32'h0;
    end else if (w_accept) begin
      if (w_full) begin
        r_ovf <= 1'b1;
      end else if (w_store) begin
        r_asm      <= 32'h0;
        r_byte_cnt <= 2'd0;
        r_waddr    <= r_waddr + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end else begin
        r_asm      <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
    end
  end

  // Instruction memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst && w_store) begin
      r_mem[r_waddr[DEPTH_LOG2-1:0]] <= w_word;
    end
  end

  assign w_fetch       = rst && (r_state == ST_RUN) && rom_ce_i;
  assign w_ridx        = rom_addr_i[DEPTH_LOG2+1:2];
  assign w_raw         = r_mem[w_ridx];
  assign w_unused_addr = ^{rom_addr_i[31:DEPTH_LOG2+2], rom_addr_i[1:0]};

`ifdef INST_ROM_ADDR_CHECK_EN
  logic w_oob;
  logic r_addr_err;

  // The full word index is compared, so aliased high addresses also count as out of range.
  assign w_oob      = rom_addr_i[31:2] >= {{(30-DEPTH_LOG2-1){1'b0}}, r_waddr};
  assign addr_err_o = r_addr_err;

  // Sticky out-of-range fetch flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr_err <= 1'b0;
    end else if (w_fetch && w_oob) begin
      r_addr_err <= 1'b1;
    end
  end

  // Zero-latency read: NOP past the loaded image, zero when idle or loading.
  always_comb begin
    w_rdata = 32'h0;
    if (w_fetch) begin
      if (w_oob) begin
        w_rdata = NOP_WORD;
      end else begin
        w_rdata = w_raw;
      end
    end else begin
      w_rdata = 32'h0;
    end
  end
`else
  // Zero-latency read: index wraps modulo the memory depth, zero when idle or loading.
  always_comb begin
    w_rdata = 32'h0;
    if (w_fetch) begin
      w_rdata = w_raw;
    end else begin
      w_rdata = 32'h0;
    end
  end
`endif

  assign rom_data_o = w_rdata;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed scenarios plus randomized
// loads compared against a byte-queue reference model of the program image.
module tb_inst_rom_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        cpu_hold_o;
  logic [10:0] ld_words_o;
  logic        ld_ovf_o;

  logic        d2_rst;
  logic        d2_valid;
  logic [7:0]  d2_data;
  logic        d2_last;
  logic        d2_ready;
  logic        d2_ce;
  logic [31:0] d2_addr;
  logic [31:0] d2_rdata;
  logic        d2_hold;
  logic [2:0]  d2_words;
  logic        d2_ovf;

`ifdef INST_ROM_ADDR_CHECK_EN
  logic        addr_err_o;
  logic        d2_addr_err;
`endif

  always #5 clk = ~clk;

  inst_rom_loader dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .cpu_hold_o(cpu_hold_o), .ld_words_o(ld_words_o), .ld_ovf_o(ld_ovf_o)
`ifdef INST_ROM_ADDR_CHECK_EN
    , .addr_err_o(addr_err_o)
`endif
  );

  inst_rom_loader #(.DEPTH_LOG2(2)) dut2 (
    .clk(clk), .rst(d2_rst), .ld_valid(d2_valid), .ld_data(d2_data), .ld_last(d2_last),
    .ld_ready(d2_ready), .rom_ce_i(d2_ce), .rom_addr_i(d2_addr), .rom_data_o(d2_rdata),
    .cpu_hold_o(d2_hold), .ld_words_o(d2_words), .ld_ovf_o(d2_ovf)
`ifdef INST_ROM_ADDR_CHECK_EN
    , .addr_err_o(d2_addr_err)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: byte image queue, word memory, word count, overflow flag.
  logic [7:0]  q[$];
  logic [31:0] m_mem [1024];
  int          m_words = 0;
  logic        m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Words land at byte_index/4, lane byte_index%4; a word starts from zero.
  task automatic model_commit(input int n, input bit complete);
    int lim;
    lim = complete ? n : (n / 4) * 4;
    for (int i = 0; i < lim; i++) begin
      if (i / 4 < 1024) begin
        if (i % 4 == 0) m_mem[i/4] = 32'h0;
        m_mem[i/4] = m_mem[i/4] | ({24'h0, q[i]} << (8 * (i % 4)));
      end
    end
    if (complete) begin
      m_words = ((n + 3) / 4 > 1024) ? 1024 : (n + 3) / 4;
      m_ovf   = (n > 4096);
    end else begin
      m_words = 0;
      m_ovf   = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_fetch(input logic [31:0] addr);
    int idx;
    idx = int'(addr >> 2);
`ifdef INST_ROM_ADDR_CHECK_EN
    if (idx >= m_words) return NOP;
    return m_mem[idx];
`else
    return m_mem[idx % 1024];
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_data = b; ld_last = last;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
  endtask

  // Send q[0..n-1]; last flag on the final byte only when with_last is set.
  task automatic send_q(input int n, input bit with_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        check("idle_ready", {31'h0, ld_ready}, 32'h1);
        @(posedge clk); #1;
      end
      if (with_last && i == n - 1) check("hold_before_last", {31'h0, cpu_hold_o}, 32'h1);
      send_byte(q[i], with_last && (i == n - 1));
    end
    if (with_last) begin
      check("hold_after_last", {31'h0, cpu_hold_o}, 32'h0);
      check("ready_in_run", {31'h0, ld_ready}, 32'h0);
    end
  endtask

  task automatic load_image(input int n, input bit gaps);
    send_q(n, 1'b1, gaps);
    model_commit(n, 1'b1);
    check("words", {21'h0, ld_words_o}, m_words);
    check("ovf", {31'h0, ld_ovf_o}, {31'h0, m_ovf});
  endtask

  task automatic do_reset();
    rst = 1'b0; rom_ce_i = 1'b1; rom_addr_i = 32'h0; #1;
    check("rst_ready", {31'h0, ld_ready}, 32'h1);
    check("rst_hold", {31'h0, cpu_hold_o}, 32'h1);
    check("rst_rdata", rom_data_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; rom_ce_i = 1'b0; #1;
    check("post_rst_words", {21'h0, ld_words_o}, 32'h0);
    check("post_rst_ovf", {31'h0, ld_ovf_o}, 32'h0);
    check("post_rst_hold", {31'h0, cpu_hold_o}, 32'h1);
    m_words = 0; m_ovf = 1'b0;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rom_ce_i = 1'b1; rom_addr_i = addr; #1;
    check(tag, rom_data_o, exp);
    rom_ce_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    rom_ce_i = 1'b0; rom_addr_i = 32'h0;
    d2_rst = 1'b0; d2_valid = 1'b0; d2_data = 8'h00; d2_last = 1'b0;
    d2_ce = 1'b0; d2_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Random 5-word image: fills mem[2] for the later raw-memory fetch.
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    load_image(20, 1'b1);
    for (int w = 0; w < 5; w++) fetch_chk("img5_fetch", 32'(w * 4), exp_fetch(32'(w * 4)));

    // Two-instruction image.
    do_reset();
    q = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    load_image(8, 1'b0);
    check("two_words", {21'h0, ld_words_o}, 32'd2);
    fetch_chk("w0", 32'h0, 32'h00100013);
    fetch_chk("w1", 32'h4, 32'h00200093);
    fetch_chk("w1_low_bits", 32'h7, 32'h00200093);
    rom_ce_i = 1'b0; rom_addr_i = 32'h0; #1;
    check("ce_off", rom_data_o, 32'h0);

    // Bytes offered in RUN are ignored.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4);
    check("run_ignore_words", {21'h0, ld_words_o}, 32'd2);
    check("run_ignore_hold", {31'h0, cpu_hold_o}, 32'h0);
    fetch_chk("run_ignore_w0", 32'h0, 32'h00100013);

    // Fetch just past the loaded image.
`ifdef INST_ROM_ADDR_CHECK_EN
    check("err_clear", {31'h0, addr_err_o}, 32'h0);
    fetch_chk("past_end", 32'h8, NOP);
    rom_ce_i = 1'b1; rom_addr_i = 32'h8;
    @(posedge clk); #1;
    rom_ce_i = 1'b0;
    check("err_set", {31'h0, addr_err_o}, 32'h1);
    @(posedge clk); #1;
    check("err_sticky", {31'h0, addr_err_o}, 32'h1);
`else
    fetch_chk("past_end_raw", 32'h8, exp_fetch(32'h8));
    fetch_chk("wrap_w0", 32'h1000, 32'h00100013);
`endif
    rom_addr_i = 32'h8; #1;
    check("past_end_ce_off", rom_data_o, 32'h0);

    // Five-byte image: trailing partial word is zero-padded.
    do_reset();
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_image(5, 1'b0);
    check("partial_words", {21'h0, ld_words_o}, 32'd2);
    fetch_chk("partial_w1", 32'h4, 32'h000000EE);
    fetch_chk("partial_w0", 32'h0, 32'hDDCCBBAA);

    // Reset in the middle of a load, then a one-word image.
    do_reset();
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    send_q(6, 1'b0, 1'b0);
    check("midload_hold", {31'h0, cpu_hold_o}, 32'h1);
    model_commit(6, 1'b0);
    do_reset();
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_image(4, 1'b0);
    fetch_chk("after_abort_w0", 32'h0, 32'h44332211);
    check("after_abort_words", {21'h0, ld_words_o}, 32'd1);
    check("after_abort_ovf", {31'h0, ld_ovf_o}, 32'h0);

    // Randomized images with random idle gaps and random fetches.
    for (int it = 0; it < 8; it++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 30);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      load_image(n, 1'b1);
      for (int k = 0; k < 4; k++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, m_words - 1)) * 32'd4 + 32'($urandom_range(0, 3));
        if (k == 3) a = a + 32'h1000;
        fetch_chk("rand_fetch", a, exp_fetch(a));
      end
    end

    // Four-word instance: 20 bytes overflow the memory while the loader drains.
    @(posedge clk); #1;
    d2_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("d2_ready", {31'h0, d2_ready}, 32'h1);
      d2_valid = 1'b1; d2_data = 8'(i + 1); d2_last = (i == 19);
      @(posedge clk); #1;
      d2_valid = 1'b0; d2_last = 1'b0;
      if (i == 15) check("d2_full_no_ovf", {31'h0, d2_ovf}, 32'h0);
      if (i == 16) check("d2_ovf_set", {31'h0, d2_ovf}, 32'h1);
    end
    check("d2_words", {29'h0, d2_words}, 32'd4);
    check("d2_ovf", {31'h0, d2_ovf}, 32'h1);
    check("d2_run_hold", {31'h0, d2_hold}, 32'h0);
    check("d2_run_ready", {31'h0, d2_ready}, 32'h0);
    d2_ce = 1'b1; d2_addr = 32'hC; #1;
    check("d2_w3", d2_rdata, 32'h100F0E0D);
    d2_ce = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
- REQ-001 Parameter DEPTH_LOG2, default 10, means log2 of the word count of the instruction memory (1024 x 32-bit words).
- REQ-002 Parameter NOP_WORD, default 32'h00000013, means the word returned for out-of-range fetches (RV32I addi x0,x0,0).
- REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
- REQ-004 Port rst, input, 1: one clock; reset is synchronous and active-low.
- REQ-005 Port ld_valid, input, 1, means a load byte is offered.
- REQ-006 Port ld_data, input, 8, carries the load byte, little-endian within each word.
- REQ-007 Port ld_last, input, 1, marks the final byte of the program image; it is qualified by ld_valid.
- REQ-008 Port ld_ready, output, 1, means the block accepts a byte this cycle.
- REQ-009 Port rom_ce_i, input, 1, is the CPU fetch enable.
- REQ-010 Port rom_addr_i, input, 32, is the CPU fetch byte address.
- REQ-011 Port rom_data_o, output, 32, is the fetched instruction.
- REQ-012 Port cpu_hold_o, output, 1, holds the CPU in reset while the image loads.
- REQ-013 Port ld_words_o, output, DEPTH_LOG2+1, is the count of words written.
- REQ-014 Port ld_ovf_o, output, 1, is a sticky flag: bytes were dropped because memory was full.

Function
- REQ-015 The block SHALL have two states: LOAD and RUN. Reset enters LOAD.
- REQ-016 In LOAD, ld_ready SHALL be 1 and cpu_hold_o SHALL be 1. In RUN, ld_ready SHALL be 0 and cpu_hold_o SHALL be 0.
- REQ-017 A byte is accepted on each edge with ld_valid=1 and ld_ready=1. The byte goes to lane byte_cnt (lane 0 = bits 7:0), and byte_cnt increments modulo 4.
- REQ-018 On the edge accepting lane 3, the SHALL write the assembled word to mem[waddr], increment waddr, and increment ld_words_o.
- REQ-019 If ld_last is accepted with byte_cnt!=3, the partial word SHALL be written with its unfilled lanes zero, and ld_words_o SHALL increment.
- REQ-020 On the edge accepting ld_last, the state SHALL go to RUN. cpu_hold_o falls in the following cycle.
- REQ-021 When waddr equals 2^DEPTH_LOG2, accepted bytes SHALL be discarded, ld_ovf_o SHALL be set, and ld_ready SHALL stay 1 so the loader drains. ld_last still transitions to RUN.
- REQ-022 rom_data_o SHALL be combinational (zero-latency), so that the word is valid in the same cycle as rom_addr_i.
- REQ-023 rom_data_o SHALL be 0 when rom_ce_i=0 or the state is LOAD.
- REQ-024 Otherwise rom_data_o SHALL be mem[rom_addr_i[DEPTH_LOG2+1:2]]. Address bits [1:0] are ignored.
- REQ-025 ld_valid=0 in LOAD SHALL change no state. ld_valid in RUN SHALL be ignored.

Reset
- REQ-026 When rst=0 at an edge, the block SHALL set: state=LOAD, byte_cnt=0, waddr=0, ld_words_o=0, ld_ovf_o=0, and the word assembly register to 0.
- REQ-027 Memory contents SHALL NOT be cleared by reset.
- REQ-028 Reset mid-load SHALL discard any partial word. Reset in RUN SHALL restart loading from word 0.
- REQ-029 During reset: ld_ready=1, cpu_hold_o=1, rom_data_o=0.

Configuration
- REQ-030 With macro INST_ROM_ADDR_CHECK_EN defined, a RUN fetch with word index >= ld_words_o SHALL return NOP_WORD and set output addr_err_o.
  - addr_err_o is a 1-bit sticky flag, cleared only by reset.
- REQ-031 Without INST_ROM_ADDR_CHECK_EN, addr_err_o SHALL not exist, and the word index SHALL wrap modulo 2^DEPTH_LOG2, returning the raw array word.

Verification
- REQ-032 Load bytes 13,00,10,00 | 93,00,20,00 with ld_last on the 8th byte, then fetch addr 0 and 4 with ce=1 -> data 32'h00100013 and 32'h00200093; ld_words_o=2; cpu_hold_o=0 one cycle after ld_last.
- REQ-033 Load 5 bytes AA,BB,CC,DD,EE with ld_last on EE, then fetch addr 4 -> 32'h000000EE; ld_words_o=2.
- REQ-034 Assert rst=0 after 6 bytes, then load 4 bytes 11,22,33,44 + last, then fetch addr 0 -> 32'h44332211; ld_words_o=1; ld_ovf_o=0.
- REQ-035 With DEPTH_LOG2=2, offer 20 bytes, last on 20th -> ld_words_o=4, ld_ovf_o=1, ld_ready=1 throughout LOAD, and state RUN afterwards.
- REQ-036 After a 2-word load, fetch addr 8 -> with INST_ROM_ADDR_CHECK_EN: 32'h00000013 and addr_err_o=1; without it: raw mem[2]. Fetch with ce=0 -> 0 in both builds.
